// File: rtl/regfile_port_arbiter_if.sv
// Bundle of the requester-side and register-file-side signals around the shared port arbiter.
// Slice i of each req_* vector belongs to requester i.
interface regfile_port_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int Naddr = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [4*NREQ-1:0]     req_we;
  logic [Naddr*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0]    req_wdata;
  logic [NREQ-1:0]       req_ack;
  logic [31:0]           req_rdata;
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [Naddr-1:0]      mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  busy;
  logic [2:0]            grant_id;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ack, req_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ack, req_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one BRAM-style register-file port among NREQ requesters.
// One transaction at a time: registered issue, fixed read-latency wait, one-cycle ack.
module regfile_port_arbiter #(
  parameter int NREQ   = 2,
  parameter int Naddr  = 4,
  parameter int RD_LAT = 1
) (
  input logic                   clk,
  input logic                   rst,
  regfile_port_arbiter_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  generate
    if (NREQ < 2 || NREQ > 8 || RD_LAT < 1 || RD_LAT > 4) begin : g_param_err
      $error("regfile_port_arbiter: NREQ must be 2..8 and RD_LAT 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   state, state_n;
  logic [2:0]               last_p0, last_n;
  logic [CNT_W-1:0]         cnt_p0, cnt_n;
  logic                     mem_en_p0, mem_en_n;
  logic [3:0]               mem_we_p0, mem_we_n;
  logic [Naddr-1:0]         mem_addr_p0, mem_addr_n;
  logic signed [DATA_W-1:0] mem_wdata_p0, mem_wdata_n;
  logic signed [DATA_W-1:0] rdata_p0, rdata_n;
  logic [NREQ-1:0]          vld_p0, vld_n;
  logic                     busy_p0, busy_n;
  logic [2:0]               grant_p0, grant_n;
  logic [2:0]               win;

  // First requesting index strictly after the previous winner, wrapping around.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] v, input logic [2:0] prev);
    logic [2:0] w;
    logic       found;
    int         idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(prev) + k) % NREQ;
      if (!found && v[idx]) begin
        w     = 3'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = rr_pick(bus.req_valid, last_p0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      last_p0      <= 3'(NREQ - 1);
      cnt_p0       <= '0;
      mem_en_p0    <= 1'b0;
      mem_we_p0    <= '0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      rdata_p0     <= '0;
      vld_p0       <= '0;
      busy_p0      <= 1'b0;
      grant_p0     <= '0;
    end else begin
      state        <= state_n;
      last_p0      <= last_n;
      cnt_p0       <= cnt_n;
      mem_en_p0    <= mem_en_n;
      mem_we_p0    <= mem_we_n;
      mem_addr_p0  <= mem_addr_n;
      mem_wdata_p0 <= mem_wdata_n;
      rdata_p0     <= rdata_n;
      vld_p0       <= vld_n;
      busy_p0      <= busy_n;
      grant_p0     <= grant_n;
    end
  end

  always_comb begin
    state_n     = state;
    last_n      = last_p0;
    cnt_n       = cnt_p0;
    mem_en_n    = mem_en_p0;
    mem_we_n    = mem_we_p0;
    mem_addr_n  = mem_addr_p0;
    mem_wdata_n = mem_wdata_p0;
    rdata_n     = rdata_p0;
    vld_n       = '0;
    grant_n     = grant_p0;

    case (state)
      S_IDLE: begin
        mem_en_n = 1'b0;
        if (|bus.req_valid) begin
          mem_en_n    = 1'b1;
          mem_we_n    = bus.req_we[int'(win)*4 +: 4];
          mem_addr_n  = bus.req_addr[int'(win)*Naddr +: Naddr];
          mem_wdata_n = bus.req_wdata[int'(win)*DATA_W +: DATA_W];
          grant_n     = win;
          last_n      = win;
          state_n     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en_n = 1'b0;
        mem_we_n = '0;
        cnt_n    = CNT_W'(RD_LAT - 1);
        state_n  = S_WAIT;
      end
      // Read data lines up with the cycle where the counter reaches zero.
      S_WAIT: begin
        if (cnt_p0 == '0) begin
          rdata_n = bus.mem_rdata;
          for (int i = 0; i < NREQ; i++) begin
            vld_n[i] = (grant_p0 == 3'(i));
          end
          state_n = S_DONE;
        end else begin
          cnt_n = cnt_p0 - 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  assign bus.mem_en    = mem_en_p0;
  assign bus.mem_we    = mem_we_p0;
  assign bus.mem_addr  = mem_addr_p0;
  assign bus.mem_wdata = mem_wdata_p0;
  assign bus.req_rdata = rdata_p0;
  assign bus.req_ack   = vld_p0;
  assign bus.busy      = busy_p0;
  assign bus.grant_id  = grant_p0;
endmodule
